ex_issue_buffer: RTL and testbench

- ID/EX stage buffer directly upstream of the 32-bit execute ALU.
- Accepts decoded instructions from ID over a valid/ready handshake and builds ALU operand B (register or extended immediate).
- Translates ALUOp/funct into the ALU's 4-bit select code.
- Holds results in a 2-entry FIFO (skid) so ID can stall cleanly when EX back-pressures; presents the head entry as ALU-ready op1/op2/sel.

---
 rtl/ex_issue_buffer.sv | 185 ++++++++++++++++++
 tb/tb_ex_issue_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_buffer.sv
// rtl/ex_issue_buffer.sv - ID/EX issue buffer: ALU decode, operand-B mux, 2-entry skid FIFO (optional EX_ISSUE_FWD_EN forwarding)
module ex_issue_buffer #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs_data,
    input  logic [WIDTH-1:0] in_rt_data,
    input  logic [15:0]      in_imm,
    input  logic             in_alu_src,
    input  logic [1:0]       in_alu_op,
    input  logic [5:0]       in_funct,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_reg_write,
`ifdef EX_ISSUE_FWD_EN
    input  logic [RADDR-1:0] in_rs,
    input  logic [RADDR-1:0] in_rt,
    input  logic             fwd_valid,
    input  logic [RADDR-1:0] fwd_rd,
    input  logic [WIDTH-1:0] fwd_data,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_sel,
    output logic [RADDR-1:0] out_rd,
    output logic             out_reg_write,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   wr_ptr, rd_ptr;
    logic   push, pop;

    logic [WIDTH-1:0] e_op1     [0:1];
    logic [WIDTH-1:0] e_op2     [0:1];
    logic [3:0]       e_sel     [0:1];
    logic [RADDR-1:0] e_rd      [0:1];
    logic             e_rw      [0:1];
    logic             e_illegal [0:1];

    logic [3:0]       dec_sel;
    logic             dec_illegal;
    logic [WIDTH-1:0] rs_val, rt_val, imm_ext, dec_op2;

    // ALUOp/funct to ALU select translation; unknown funct is flagged illegal
    always_comb begin
        dec_sel     = 4'b1111;
        dec_illegal = 1'b0;
        case (in_alu_op)
            2'b00: dec_sel = 4'b0010;
            2'b01: dec_sel = 4'b0110;
            2'b11: dec_sel = 4'b0001;
            default: begin
                case (in_funct)
                    6'b100000: dec_sel = 4'b0010;
                    6'b100010: dec_sel = 4'b0110;
                    6'b100100: dec_sel = 4'b0000;
                    6'b100101: dec_sel = 4'b0001;
                    6'b101010: dec_sel = 4'b0111;
                    6'b100111: dec_sel = 4'b1100;
                    default: begin
                        dec_sel     = 4'b1111;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

`ifdef EX_ISSUE_FWD_EN
    // Register operands, replaced by the in-flight result when it targets them (never r0)
    always_comb begin
        rs_val = in_rs_data;
        rt_val = in_rt_data;
        if (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs))
            rs_val = fwd_data;
        if (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rt))
            rt_val = fwd_data;
    end
`else
    // Register operands straight from the register file read ports
    always_comb begin
        rs_val = in_rs_data;
        rt_val = in_rt_data;
    end
`endif

    // Operand B: ORI-style (ALUOp 11) immediates zero-extend, all others sign-extend
    always_comb begin
        if (in_alu_op == 2'b11)
            imm_ext = {{(WIDTH-16){1'b0}}, in_imm};
        else
            imm_ext = {{(WIDTH-16){in_imm[15]}}, in_imm};
        dec_op2 = in_alu_src ? imm_ext : rt_val;
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Occupancy next-state; flush empties the buffer and drops that cycle's push/pop
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)
                    state_nxt = FULL;
                else if (pop && !push)
                    state_nxt = EMPTY;
            end
            FULL: if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
        if (flush)
            state_nxt = EMPTY;
    end

    // Handshake and head-entry outputs; in_ready depends on state only
    always_comb begin
        in_ready      = (state != FULL) && !rst;
        out_valid     = (state != EMPTY);
        alu_op1       = e_op1[rd_ptr];
        alu_op2       = e_op2[rd_ptr];
        alu_sel       = e_sel[rd_ptr];
        out_rd        = e_rd[rd_ptr];
        out_reg_write = e_rw[rd_ptr];
        out_illegal   = e_illegal[rd_ptr];
    end

    // Entry storage and pointers; popped slots are cleared so an empty buffer reads zero
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                e_op1[i]     <= '0;
                e_op2[i]     <= '0;
                e_sel[i]     <= '0;
                e_rd[i]      <= '0;
                e_rw[i]      <= 1'b0;
                e_illegal[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                e_op1[rd_ptr]     <= '0;
                e_op2[rd_ptr]     <= '0;
                e_sel[rd_ptr]     <= '0;
                e_rd[rd_ptr]      <= '0;
                e_rw[rd_ptr]      <= 1'b0;
                e_illegal[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            if (push) begin
                e_op1[wr_ptr]     <= rs_val;
                e_op2[wr_ptr]     <= dec_op2;
                e_sel[wr_ptr]     <= dec_sel;
                e_rd[wr_ptr]      <= in_rd;
                e_rw[wr_ptr]      <= in_reg_write;
                e_illegal[wr_ptr] <= dec_illegal;
                wr_ptr            <= ~wr_ptr;
            end
        end
    end

endmodule

// File: tb/tb_ex_issue_buffer.sv
// tb/tb_ex_issue_buffer.sv - scoreboard bench for ex_issue_buffer
module tb_ex_issue_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_rs_data = '0;
    logic [31:0] in_rt_data = '0;
    logic [15:0] in_imm = '0;
    logic        in_alu_src = 1'b0;
    logic [1:0]  in_alu_op = '0;
    logic [5:0]  in_funct = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = '0;
    logic [31:0] fwd_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_op1, alu_op2;
    logic [3:0]  alu_sel;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_illegal;

    logic tb_ready = 1'b0;
    logic rnd_ready = 1'b0;
    logic rand_mode = 1'b0;
    assign out_ready = rand_mode ? rnd_ready : tb_ready;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    ex_issue_buffer #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_funct(in_funct),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
`ifdef EX_ISSUE_FWD_EN
        .in_rs(in_rs), .in_rt(in_rt), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: every consumed head entry must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got op1=%h op2=%h sel=%b, required no output", alu_op1, alu_op2, alu_sel);
            end else begin
                mon_e = q.pop_front();
                if ({alu_op1, alu_op2, alu_sel, out_rd, out_reg_write, out_illegal} !==
                    {mon_e.op1, mon_e.op2, mon_e.sel, mon_e.rd, mon_e.rw, mon_e.ill}) begin
                    errors++;
                    $display("FAIL scoreboard: got op1=%h op2=%h sel=%b rd=%0d rw=%b ill=%b, required op1=%h op2=%h sel=%b rd=%0d rw=%b ill=%b",
                             alu_op1, alu_op2, alu_sel, out_rd, out_reg_write, out_illegal,
                             mon_e.op1, mon_e.op2, mon_e.sel, mon_e.rd, mon_e.rw, mon_e.ill);
                end
            end
        end
    end

    // Call at posedge+1; holds the instruction until accepted and records its expected entry
    task automatic send(input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [15:0] imm,
                        input logic src, input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] rd, input logic rw);
        exp_t e;
        logic [31:0] rtv;
        int n;
        e.op1 = rs_d;
        rtv = rt_d;
`ifdef EX_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs) e.op1 = fwd_data;
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rt) rtv = fwd_data;
`endif
        if (!src)          e.op2 = rtv;
        else if (op == 2'b11) e.op2 = {16'h0000, imm};
        else               e.op2 = {{16{imm[15]}}, imm};
        e.ill = 1'b0;
        case (op)
            2'b00: e.sel = 4'b0010;
            2'b01: e.sel = 4'b0110;
            2'b11: e.sel = 4'b0001;
            default: begin
                case (fn)
                    6'h20: e.sel = 4'b0010;
                    6'h22: e.sel = 4'b0110;
                    6'h24: e.sel = 4'b0000;
                    6'h25: e.sel = 4'b0001;
                    6'h2a: e.sel = 4'b0111;
                    6'h27: e.sel = 4'b1100;
                    default: begin e.sel = 4'b1111; e.ill = 1'b1; end
                endcase
            end
        endcase
        e.rd = rd;
        e.rw = rw;
        in_rs_data = rs_d; in_rt_data = rt_d; in_imm = imm; in_alu_src = src;
        in_alu_op = op; in_funct = fn; in_rd = rd; in_reg_write = rw;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%b, required 1 within 40 cycles", in_ready);
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (alu_sel !== 4'b0000) begin errors++; $display("FAIL reset_alu_sel: got %b required 0000", alu_sel); end
        checks++; if (alu_op1 !== 32'h0) begin errors++; $display("FAIL reset_alu_op1: got %h required 0", alu_op1); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        tb_ready = 1'b1;
        send(32'd9, 32'd4, 16'h0000, 1'b0, 2'b10, 6'h22, 5'd3, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rtype_latency: out_valid got %b required 1", out_valid); end
        checks++; if (alu_sel !== 4'b0110) begin errors++; $display("FAIL rtype_sel: got %b required 0110", alu_sel); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rtype_popped: out_valid got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_imm();
        tb_ready = 1'b1;
        send(32'd100, 32'd7, 16'hFFFC, 1'b1, 2'b00, 6'h00, 5'd8, 1'b1);
        @(negedge clk);
        checks++; if (alu_op2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_sext: got %h required fffffffc", alu_op2); end
        @(posedge clk);
        #1;
        send(32'd100, 32'd7, 16'hFFFC, 1'b1, 2'b11, 6'h00, 5'd9, 1'b1);
        @(negedge clk);
        checks++; if (alu_op2 !== 32'h0000_FFFC) begin errors++; $display("FAIL imm_zext: got %h required 0000fffc", alu_op2); end
        checks++; if (alu_sel !== 4'b0001) begin errors++; $display("FAIL imm_or_sel: got %b required 0001", alu_sel); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        tb_ready = 1'b0;
        send(32'hA0A0_0001, 32'h1, 16'h0, 1'b0, 2'b10, 6'h20, 5'd1, 1'b1);
        send(32'hB0B0_0002, 32'h2, 16'h0, 1'b0, 2'b10, 6'h2a, 5'd2, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %b required 1", out_valid); end
        @(posedge clk);
        #1;
        tb_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_no_comb_path: got %b required 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b required 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained_out_valid: got %b required 0", out_valid); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL drained_order: %0d entries left, required 0", q.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        tb_ready = 1'b0;
        send(32'h11, 32'h1, 16'h0, 1'b0, 2'b01, 6'h00, 5'd4, 1'b1);
        send(32'h22, 32'h2, 16'h0, 1'b0, 2'b01, 6'h00, 5'd5, 1'b1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_rs_data = 32'hDEAD_BEEF;
        q.delete();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b required 1", in_ready); end
        checks++; if (alu_op1 !== 32'h0) begin errors++; $display("FAIL flush_zeroed: alu_op1 got %h required 0", alu_op1); end
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_push_discarded: out_valid got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        tb_ready = 1'b0;
        send(32'h33, 32'h3, 16'h0, 1'b0, 2'b00, 6'h00, 5'd6, 1'b1);
        send(32'h44, 32'h4, 16'h0, 1'b0, 2'b00, 6'h00, 5'd7, 1'b1);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b required 0", out_valid); end
        checks++; if ({alu_op2, out_rd, out_reg_write} !== 38'h0) begin errors++; $display("FAIL rst_mid_zeroed: op2=%h rd=%0d rw=%b required 0", alu_op2, out_rd, out_reg_write); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        tb_ready = 1'b1;
        send(32'h5, 32'h6, 16'h0, 1'b0, 2'b10, 6'h00, 5'd10, 1'b1);
        @(negedge clk);
        checks++; if (alu_sel !== 4'b1111) begin errors++; $display("FAIL illegal_sel: got %b required 1111", alu_sel); end
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b required 1", out_illegal); end
        @(posedge clk);
        #1;
    endtask

`ifdef EX_ISSUE_FWD_EN
    task automatic test_forward();
        tb_ready = 1'b1;
        in_rs = 5'd5; in_rt = 5'd6;
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h1234;
        send(32'hAAAA_AAAA, 32'h7, 16'h0, 1'b0, 2'b00, 6'h00, 5'd1, 1'b1);
        @(negedge clk);
        checks++; if (alu_op1 !== 32'h1234) begin errors++; $display("FAIL fwd_rs: got %h required 00001234", alu_op1); end
        @(posedge clk);
        #1;
        in_rs = 5'd0; fwd_rd = 5'd0;
        send(32'hAAAA_AAAA, 32'h7, 16'h0, 1'b0, 2'b00, 6'h00, 5'd1, 1'b1);
        @(negedge clk);
        checks++; if (alu_op1 !== 32'hAAAA_AAAA) begin errors++; $display("FAIL fwd_r0: got %h required aaaaaaaa", alu_op1); end
        @(posedge clk);
        #1;
        fwd_valid = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [5:0] fn_tab [0:6];
        int n;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
        fn_tab[4] = 6'h2a; fn_tab[5] = 6'h27; fn_tab[6] = 6'h3f;
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_rs = 5'($urandom_range(0, 7));
            in_rt = 5'($urandom_range(0, 7));
            fwd_valid = 1'($urandom_range(0, 1));
            fwd_rd = 5'($urandom_range(0, 7));
            fwd_data = $urandom;
            send($urandom, $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), fn_tab[$urandom_range(0, 6)],
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        fwd_valid = 1'b0;
        rand_mode = 1'b0;
        tb_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d entries left, required 0", q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: out_valid got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_imm();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_illegal();
`ifdef EX_ISSUE_FWD_EN
        test_forward();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
